// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if
// Groups the producer-side beat bus and the fifo_gray write-port signals
// that the arbiter sits between.
//   master : arbiter side (drives req_ready, fifo_push, fifo_data, grant_id, grant_active)
//   slave  : producer / FIFO side (drives req_valid, req_last, req_data, fifo_full)
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_push;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic [GW-1:0]                 grant_id;
  logic                          grant_active;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_push, fifo_data, grant_id, grant_active
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_push, fifo_data, grant_id, grant_active
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
// Round-robin arbiter sharing one fifo_gray write port among NUM_REQ
// producers. A winner keeps the port until its burst ends (req_last) or
// MAX_BURST beats have been pushed in the current grant.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus         : fifo_push_arbiter_if.master (request beats, FIFO push, grant status)
//   stall_clr   : synchronous clear of stall_cnt   (FIFO_PUSH_ARBITER_STATS_EN only)
//   stall_cnt   : saturating count of full-blocked cycles (FIFO_PUSH_ARBITER_STATS_EN only)
// Optional feature macro: FIFO_PUSH_ARBITER_STATS_EN
//
// state | meaning
// IDLE  | arbitrate: first valid requester after grant_id wins
// BURST | grant_id owns the FIFO until last beat or MAX_BURST beats
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef FIFO_PUSH_ARBITER_STATS_EN
  input  logic                 stall_clr,
  output logic [15:0]          stall_cnt,
`endif
  fifo_push_arbiter_if.master  bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [GW-1:0] sel;
  logic          sel_valid;
  logic          sel_last;
  logic          xfer;

  // Selection. In IDLE the lowest rotation distance from grant_id wins, so
  // the loop runs from the farthest candidate down and the nearest overwrites.
  always_comb begin
    sel       = grant_id_q;
    sel_valid = 1'b0;
    if (state_q == BURST) begin
      sel_valid = bus.req_valid[grant_id_q];
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (bus.req_valid[GW'((int'(grant_id_q) + k) % NUM_REQ)]) begin
          sel       = GW'((int'(grant_id_q) + k) % NUM_REQ);
          sel_valid = 1'b1;
        end
      end
    end
  end

  // Gating with rst_n keeps push/ready low for the whole reset, not just
  // after the registers settle.
  assign xfer = sel_valid & ~bus.fifo_full & rst_n;

  always_comb begin
    sel_last      = 1'b0;
    bus.fifo_data = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == sel) begin
        sel_last         = bus.req_last[i];
        bus.fifo_data    = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        bus.req_ready[i] = xfer;
      end
    end
  end

  assign bus.fifo_push    = xfer;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_active = (state_q == BURST);

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          grant_id_d = sel;
          beat_cnt_d = CW'(1);
          if (!sel_last && (MAX_BURST > 1)) state_d = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (sel_last || (beat_cnt_q + CW'(1) == CW'(MAX_BURST))) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= GW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (stall_clr) begin
      stall_q <= '0;
    end else if (sel_valid && bus.fifo_full && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
Round-robin arbiter that shares one fifo_gray write port among NUM_REQ producers.
- Each producer sends bursts of beats, delimited by a last flag.
- Once a producer wins, it keeps the FIFO until its burst ends or the MAX_BURST beat limit forces a release.
- Sits directly in front of fifo_gray: drives push/data_in and obeys full.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, beat width; matches fifo_gray DATA_WIDTH
MAX_BURST, 8, maximum beats per grant before forced release (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_last  input  NUM_REQ  per-requester final beat of burst
req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot or zero; beat of requester i accepted this cycle
fifo_full  input  1  fifo_gray full flag
fifo_push  output  1  push strobe to fifo_gray
fifo_data  output  DATA_WIDTH  data to fifo_gray data_in
grant_id  output  $clog2(NUM_REQ)  current or last owner index
grant_active  output  1  high while in BURST state

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: state=IDLE, grant_id=NUM_REQ-1 (so requester 0 has first priority), beat_cnt=0, grant_active=0. Outputs fifo_push and req_ready are 0 during reset.
- Transfer rule: a beat transfers when the selected requester has req_valid=1 and fifo_full=0.
  - fifo_push = req_ready[sel] = 1 in the same cycle (combinational; zero-cycle latency).
  - fifo_data = req_data[sel]; the value is don't-care when fifo_push=0.
- States: IDLE and BURST.
- IDLE:
  - sel = first valid requester searching upward from grant_id+1 modulo NUM_REQ.
  - If no req_valid is high: no push, stay in IDLE.
  - If fifo_full=1: no push; arbitration is re-evaluated next cycle; grant_id unchanged.
  - On transfer: grant_id<=sel, beat_cnt<=1.
    - If req_last[sel]=1 or MAX_BURST==1: stay in IDLE.
    - Otherwise: go to BURST.
- BURST:
  - sel=grant_id; all other requesters get req_ready=0 regardless of their valid.
  - Owner's req_valid low or fifo_full=1: hold state; beat_cnt unchanged.
  - On transfer: beat_cnt<=beat_cnt+1.
    - If req_last=1 or beat_cnt+1==MAX_BURST: go to IDLE.
    - An owner released by MAX_BURST continues its burst only after winning arbitration again; it has the lowest priority in that round.
- Round-robin pointer: updates only on an accepted beat in IDLE. It is never updated in BURST or on a blocked cycle.
- beat_cnt: width $clog2(MAX_BURST+1); must never wrap.
- fifo_full=1: never assert fifo_push, so the FIFO cannot overflow.
- Reset mid-burst: returns to IDLE immediately with the reset values above. A partially sent burst is not tracked.
- req_last on a non-granted requester has no effect.
- Requesters must hold req_valid/req_data/req_last stable until req_ready (valid/ready contract). The arbiter does not check this.

Optional Feature:
FIFO_PUSH_ARBITER_STATS_EN
- Defined: adds output stall_cnt[15:0], reset to 0.
  - Increments each cycle where the selected requester has req_valid=1 and fifo_full=1.
  - Saturates at 16'hFFFF.
  - Adds input stall_clr (1 bit, synchronous clear; clear has priority over increment).
- Undefined: stall_cnt and stall_clr ports do not exist; no counter logic.

Test Plan:
- Reset, then requesters 0 and 2 each present one beat with last=1 (0xA0, 0xA2) for 2 cycles -> cycle 1 pushes 0xA0 with grant_id=0; cycle 2 pushes 0xA2 with grant_id=2.
- Requester 1 sends a 3-beat burst (0x11, 0x12, 0x13 last) while requester 3 is valid -> three consecutive pushes from req 1 with grant_active=1 on beats 2-3; req 3 is served on the 4th cycle.
- MAX_BURST=8; requester 0 sends 10 beats without last while requester 1 is valid -> 8 beats from req 0, then req 1 is granted, then req 0 resumes with beats 9-10.
- Hold fifo_full=1 for 4 cycles mid-burst (after beat 2 of 4) -> no fifo_push and req_ready=0 during the stall; beats 3-4 follow after full drops; no beat lost or duplicated.
- Assert rst_n=0 during beat 2 of a burst from req 2 -> grant_active=0 and grant_id=NUM_REQ-1 asynchronously; after release, req 0 wins if valid.
- With FIFO_PUSH_ARBITER_STATS_EN: 5 stall cycles -> stall_cnt=5; stall_clr pulse -> 0. Force 70000 stall cycles -> stall_cnt=16'hFFFF.
